dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 243 ++++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory responder, 64-bit words, byte lanes.
// One request in flight: accept in IDLE, wait LAT cycles, hold response until taken.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   req_valid/ready   request handshake (ready only in IDLE)
//   req_rd, req_wr    load / store select (both 0 = no-op, both 1 = error)
//   req_wr_en[7:0]    store byte-lane enables
//   req_addr[63:0]    byte address; word = addr[3+:log2(DEPTH)], lane = addr[2:0]
//   req_data[63:0]    lane-positioned store data
//   req_unit[3:0]     one-hot load size: byte/half/word/dword
//   req_ext           load sign-extend (1) or zero-extend (0)
//   rsp_valid/ready   response handshake
//   rsp_data[63:0]    right-aligned, extended load data (0 for stores/errors)
//   rsp_err           access rejected, no side effect
//
// Build option: define DMEM_MISALIGN_CHECK_EN to fault misaligned loads;
// otherwise misaligned loads are silently aligned down to the unit size.

module dmem_responder #(
  parameter int DEPTH = 512,
  parameter int LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [7:0]  req_wr_en,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_data,
  input  logic [3:0]  req_unit,
  input  logic        req_ext,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        rsp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] SPAN = 64'(DEPTH) * 64'd8;
  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [3:0]  r_cnt;

  logic        r_rd;
  logic        r_wr;
  logic [7:0]  r_wr_en;
  logic [63:0] r_addr;
  logic [63:0] r_data;
  logic [3:0]  r_unit;
  logic        r_ext;

  logic [63:0] r_mem [DEPTH];

  logic [63:0] r_rsp_data;
  logic        r_rsp_err;

  logic          w_accept;
  logic          w_exec;
  logic [AW-1:0] w_idx;
  logic [63:0]   w_word;
  logic          w_is_ld;
  logic          w_is_st;
  logic          w_range_err;
  logic          w_onehot;
  logic          w_misalign;
  logic          w_err;
  logic [2:0]    w_off;
  logic [63:0]   w_shift;
  logic [63:0]   w_load;
  logic [63:0]   w_rsp;
  logic          w_wr_mem;

  // ---------------- control FSM ----------------

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_accept = req_valid & req_ready;
  assign w_exec   = (r_state == S_WAIT) && (r_cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= CNT_LOAD;
    end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Request fields are frozen at accept; the bus may change afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_wr_en <= 8'd0;
      r_addr  <= 64'd0;
      r_data  <= 64'd0;
      r_unit  <= 4'd0;
      r_ext   <= 1'b0;
    end else if (w_accept) begin
      r_rd    <= req_rd;
      r_wr    <= req_wr;
      r_wr_en <= req_wr_en;
      r_addr  <= req_addr;
      r_data  <= req_data;
      r_unit  <= req_unit;
      r_ext   <= req_ext;
    end
  end

  // ---------------- access decode ----------------

  assign w_idx       = r_addr[3 +: AW];
  assign w_word      = r_mem[w_idx];
  assign w_is_ld     = r_rd & ~r_wr;
  assign w_is_st     = r_wr & ~r_rd;
  assign w_range_err = (r_addr >= SPAN);
  assign w_onehot    = $onehot(r_unit);

`ifdef DMEM_MISALIGN_CHECK_EN
  always_comb begin
    w_off      = r_addr[2:0];
    w_misalign = 1'b0;
    if (w_is_ld) begin
      w_misalign = (r_unit[1] & r_addr[0])
                 | (r_unit[2] & (|r_addr[1:0]))
                 | (r_unit[3] & (|r_addr[2:0]));
    end
  end
`else
  // Misaligned loads are pulled down to the unit's natural boundary.
  always_comb begin
    w_misalign = 1'b0;
    w_off      = r_addr[2:0];
    if (r_unit[3]) begin
      w_off = 3'b000;
    end else if (r_unit[2]) begin
      w_off = {r_addr[2], 2'b00};
    end else if (r_unit[1]) begin
      w_off = {r_addr[2:1], 1'b0};
    end
  end
`endif

  // A no-op carries no address semantics and never faults.
  assign w_err = (r_rd & r_wr)
               | ((r_rd | r_wr) & w_range_err)
               | (w_is_ld & ~w_onehot)
               | w_misalign;

  assign w_shift = w_word >> {w_off, 3'b000};

  always_comb begin
    w_load = 64'd0;
    case (r_unit)
      4'b0001: w_load = {{56{r_ext & w_shift[7]}},  w_shift[7:0]};
      4'b0010: w_load = {{48{r_ext & w_shift[15]}}, w_shift[15:0]};
      4'b0100: w_load = {{32{r_ext & w_shift[31]}}, w_shift[31:0]};
      4'b1000: w_load = w_shift;
      default: w_load = 64'd0;
    endcase
  end

  assign w_rsp = (w_is_ld & ~w_err) ? w_load : 64'd0;

  // Reset on the execute edge wins: the pending store is dropped.
  assign w_wr_mem = w_exec & w_is_st & ~w_err & ~rst;

  // ---------------- storage ----------------

  always_ff @(posedge clk) begin
    if (w_wr_mem) begin
      for (int i = 0; i < 8; i++) begin
        if (r_wr_en[i]) begin
          r_mem[w_idx][8*i +: 8] <= r_data[8*i +: 8];
        end
      end
    end
  end

  // ---------------- response ----------------

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_data <= 64'd0;
      r_rsp_err  <= 1'b0;
    end else if (w_exec) begin
      r_rsp_data <= w_rsp;
      r_rsp_err  <= w_err;
    end else if (r_state == S_RESP && rsp_ready) begin
      r_rsp_data <= 64'd0;
      r_rsp_err  <= 1'b0;
    end
  end

  assign rsp_data = r_rsp_data;
  assign rsp_err  = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized + directed bench for dmem_responder.
// Reference: byte-level memory image with size/offset/extend arithmetic.

module tb_dmem_responder;

  localparam int DEPTH = 512;
  localparam int LAT   = 2;
  localparam int NW    = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_rd = 1'b0;
  logic        req_wr = 1'b0;
  logic [7:0]  req_wr_en = '0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_data = '0;
  logic [3:0]  req_unit = '0;
  logic        req_ext = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_data;
  logic        rsp_err;

  int n_vec = 0;
  int n_bad = 0;

  logic [63:0] mem_m [NW];

  dmem_responder #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rd    (req_rd),
    .req_wr    (req_wr),
    .req_wr_en (req_wr_en),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_unit  (req_unit),
    .req_ext   (req_ext),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  function automatic int nbytes(input logic [3:0] unit);
    if (unit == 4'b0001) return 1;
    if (unit == 4'b0010) return 2;
    if (unit == 4'b0100) return 4;
    return 8;
  endfunction

  function automatic logic ref_err(
    input logic rd, input logic wr,
    input logic [63:0] addr, input logic [3:0] unit);
    if (!rd && !wr) return 1'b0;
    if (rd && wr) return 1'b1;
    if (addr >= 64'(DEPTH * 8)) return 1'b1;
    if (rd && $countones(unit) != 1) return 1'b1;
`ifdef DMEM_MISALIGN_CHECK_EN
    if (rd && (int'(addr[2:0]) % nbytes(unit)) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [63:0] ref_load(
    input logic [63:0] w, input logic [63:0] addr,
    input logic [3:0] unit, input logic ext);
    int n;
    int off;
    logic [63:0] mask;
    logic [63:0] v;
    n = nbytes(unit);
    off = int'(addr[2:0]);
    off = off - (off % n);
    mask = (n == 8) ? '1 : ((64'd1 << (8 * n)) - 64'd1);
    v = (w >> (8 * off)) & mask;
    if (ext && n < 8 && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [63:0] ref_rsp(
    input logic rd, input logic wr, input logic [63:0] addr,
    input logic [3:0] unit, input logic ext);
    if (ref_err(rd, wr, addr, unit)) return 64'd0;
    if (!(rd && !wr)) return 64'd0;
    return ref_load(mem_m[addr[7:3]], addr, unit, ext);
  endfunction

  task automatic model_store(
    input logic rd, input logic wr, input logic [7:0] wen,
    input logic [63:0] addr, input logic [63:0] data);
    if (wr && !rd && !ref_err(rd, wr, addr, 4'b0001)) begin
      for (int i = 0; i < 8; i++) begin
        if (wen[i]) mem_m[addr[7:3]][8*i +: 8] = data[8*i +: 8];
      end
    end
  endtask

  // Drives one request, returns the response and accept-to-valid cycles.
  task automatic xact(
    input logic rd, input logic wr, input logic [7:0] wen,
    input logic [63:0] addr, input logic [63:0] data,
    input logic [3:0] unit, input logic ext,
    output logic [63:0] d, output logic e, output int lat);
    int guard;
    @(negedge clk);
    req_rd = rd;
    req_wr = wr;
    req_wr_en = wen;
    req_addr = addr;
    req_data = data;
    req_unit = unit;
    req_ext = ext;
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_rd = 1'($urandom);
    req_wr = 1'($urandom);
    req_wr_en = 8'($urandom);
    req_addr = {$urandom, $urandom};
    req_data = {$urandom, $urandom};
    req_unit = 4'($urandom);
    req_ext = 1'($urandom);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    d = rsp_data;
    e = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready got %b want 1", req_ready);
    end
    n_vec++;
    if (rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_valid got %b want 0", rsp_valid);
    end
    n_vec++;
    if (rsp_data !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_data got %h want 0", rsp_data);
    end
    n_vec++;
    if (rsp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_err got %b want 0", rsp_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_fill;
    logic [63:0] d;
    logic e;
    int lat;
    logic [63:0] v;
    for (int i = 0; i < NW; i++) begin
      v = {$urandom, $urandom};
      xact(1'b0, 1'b1, 8'hFF, 64'(i * 8), v, 4'b1000, 1'b0, d, e, lat);
      model_store(1'b0, 1'b1, 8'hFF, 64'(i * 8), v);
      n_vec++;
      if (lat !== LAT || e !== 1'b0 || d !== 64'd0) begin
        n_bad++;
        $display("FAIL fill[%0d] got lat=%0d err=%b d=%h want lat=%0d err=0 d=0",
                 i, lat, e, d, LAT);
      end
    end
  endtask

  task automatic test_directed;
    logic [63:0] d;
    logic e;
    int lat;
    xact(1'b0, 1'b1, 8'hFF, 64'h10, 64'h8877665544332211,
         4'b1000, 1'b0, d, e, lat);
    model_store(1'b0, 1'b1, 8'hFF, 64'h10, 64'h8877665544332211);
    xact(1'b1, 1'b0, 8'h00, 64'h10, 64'h0, 4'b1000, 1'b0, d, e, lat);
    n_vec++;
    if (lat !== LAT || e !== 1'b0 || d !== 64'h8877665544332211) begin
      n_bad++;
      $display("FAIL ld_dword got lat=%0d err=%b d=%h want lat=2 err=0 d=8877665544332211",
               lat, e, d);
    end
    xact(1'b1, 1'b0, 8'h00, 64'h17, 64'h0, 4'b0001, 1'b1, d, e, lat);
    n_vec++;
    if (e !== 1'b0 || d !== 64'hFFFFFFFFFFFFFF88) begin
      n_bad++;
      $display("FAIL ld_byte_s got err=%b d=%h want err=0 d=ffffffffffffff88", e, d);
    end
    xact(1'b1, 1'b0, 8'h00, 64'h17, 64'h0, 4'b0001, 1'b0, d, e, lat);
    n_vec++;
    if (e !== 1'b0 || d !== 64'h0000000000000088) begin
      n_bad++;
      $display("FAIL ld_byte_u got err=%b d=%h want err=0 d=88", e, d);
    end
    xact(1'b0, 1'b1, 8'h0C, 64'h10, 64'h00000000AABB0000,
         4'b1000, 1'b0, d, e, lat);
    model_store(1'b0, 1'b1, 8'h0C, 64'h10, 64'h00000000AABB0000);
    xact(1'b1, 1'b0, 8'h00, 64'h10, 64'h0, 4'b0100, 1'b0, d, e, lat);
    n_vec++;
    if (e !== 1'b0 || d !== 64'h00000000AABB2211) begin
      n_bad++;
      $display("FAIL ld_word_lane got err=%b d=%h want err=0 d=aabb2211", e, d);
    end
    xact(1'b1, 1'b0, 8'h00, 64'h11, 64'h0, 4'b0010, 1'b0, d, e, lat);
    n_vec++;
`ifdef DMEM_MISALIGN_CHECK_EN
    if (e !== 1'b1 || d !== 64'd0) begin
      n_bad++;
      $display("FAIL ld_half_mis got err=%b d=%h want err=1 d=0", e, d);
    end
`else
    if (e !== 1'b0 || d !== 64'h2211) begin
      n_bad++;
      $display("FAIL ld_half_mis got err=%b d=%h want err=0 d=2211", e, d);
    end
`endif
    xact(1'b1, 1'b0, 8'h00, 64'h1000, 64'h0, 4'b0010, 1'b0, d, e, lat);
    n_vec++;
    if (lat !== LAT || e !== 1'b1 || d !== 64'd0) begin
      n_bad++;
      $display("FAIL ld_range got lat=%0d err=%b d=%h want lat=2 err=1 d=0", lat, e, d);
    end
    xact(1'b1, 1'b1, 8'hFF, 64'h18, 64'hDEAD, 4'b1000, 1'b0, d, e, lat);
    n_vec++;
    if (e !== 1'b1 || d !== 64'd0) begin
      n_bad++;
      $display("FAIL rd_wr_both got err=%b d=%h want err=1 d=0", e, d);
    end
    xact(1'b1, 1'b0, 8'h00, 64'h18, 64'h0, 4'b1000, 1'b0, d, e, lat);
    n_vec++;
    if (e !== 1'b0 || d !== mem_m[3]) begin
      n_bad++;
      $display("FAIL both_no_write got d=%h want %h", d, mem_m[3]);
    end
  endtask

  task automatic test_hold;
    int lat;
    @(negedge clk);
    req_rd = 1'b1;
    req_wr = 1'b0;
    req_addr = 64'h10;
    req_unit = 4'b1000;
    req_ext = 1'b0;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 ||
          rsp_data !== 64'h88776655AABB2211) begin
        n_bad++;
        $display("FAIL hold[%0d] got v=%b rdy=%b d=%h want v=1 rdy=0 d=88776655aabb2211",
                 i, rsp_valid, req_ready, rsp_data);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    n_vec++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL hold_release got v=%b rdy=%b want v=0 rdy=1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_wait;
    logic [63:0] d;
    logic e;
    int lat;
    @(negedge clk);
    req_rd = 1'b0;
    req_wr = 1'b1;
    req_wr_en = 8'hFF;
    req_addr = 64'h20;
    req_data = ~mem_m[4];
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL rst_wait[%0d] got v=%b rdy=%b want v=0 rdy=1",
                 i, rsp_valid, req_ready);
      end
      @(posedge clk);
      #1;
    end
    xact(1'b1, 1'b0, 8'h00, 64'h20, 64'h0, 4'b1000, 1'b0, d, e, lat);
    n_vec++;
    if (e !== 1'b0 || d !== mem_m[4]) begin
      n_bad++;
      $display("FAIL rst_wait_mem got d=%h want %h", d, mem_m[4]);
    end
    @(negedge clk);
    req_rd = 1'b1;
    req_wr = 1'b0;
    req_addr = 64'h20;
    req_unit = 4'b1000;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_vec++;
    if (rsp_valid !== 1'b0 || rsp_data !== 64'd0 || rsp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_resp got v=%b d=%h e=%b want 0 0 0",
               rsp_valid, rsp_data, rsp_err);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [63:0] exp2;
    exp2 = ref_rsp(1'b1, 1'b0, 64'h2A, 4'b0010, 1'b1);
    @(negedge clk);
    req_rd = 1'b1;
    req_wr = 1'b0;
    req_addr = 64'h08;
    req_unit = 4'b1000;
    req_ext = 1'b0;
    req_valid = 1'b1;
    lat = 0;
    @(posedge clk);
    #1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    req_addr = 64'h2A;
    req_unit = 4'b0010;
    req_ext = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_release got rdy=%b v=%b want rdy=1 v=0", req_ready, rsp_valid);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n_vec++;
    if (req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_accept got rdy=%b want 0", req_ready);
    end
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_vec++;
    if (lat !== LAT || rsp_data !== exp2 || rsp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_second got lat=%0d d=%h e=%b want lat=%0d d=%h e=0",
               lat, rsp_data, rsp_err, LAT, exp2);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_random;
    logic [63:0] d;
    logic e;
    int lat;
    logic rd;
    logic wr;
    logic [7:0] wen;
    logic [63:0] addr;
    logic [63:0] data;
    logic [3:0] unit;
    logic ext;
    logic [63:0] exp_d;
    logic exp_e;
    int k;
    for (int it = 0; it < 300; it++) begin
      k = $urandom_range(0, 99);
      rd = (k < 45) || (k >= 95);
      wr = (k >= 45 && k < 85) || (k >= 95);
      wen = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      data = {$urandom, $urandom};
      ext = 1'($urandom);
      unit = 4'b0001 << $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) unit = 4'($urandom);
      addr = 64'($urandom_range(0, NW * 8 - 1));
      if ((rd || wr) && $urandom_range(0, 11) == 0) begin
        addr = ($urandom_range(0, 1) == 0) ?
               64'h1000 + 64'($urandom_range(0, 4095)) :
               {$urandom, $urandom} | 64'h1000;
      end
      exp_e = ref_err(rd, wr, addr, unit);
      exp_d = ref_rsp(rd, wr, addr, unit, ext);
      xact(rd, wr, wen, addr, data, unit, ext, d, e, lat);
      model_store(rd, wr, wen, addr, data);
      n_vec++;
      if (lat !== LAT) begin
        n_bad++;
        $display("FAIL rnd_lat[%0d] got %0d want %0d", it, lat, LAT);
      end
      n_vec++;
      if (e !== exp_e) begin
        n_bad++;
        $display("FAIL rnd_err[%0d] rd=%b wr=%b a=%h u=%b got %b want %b",
                 it, rd, wr, addr, unit, e, exp_e);
      end
      n_vec++;
      if (d !== exp_d) begin
        n_bad++;
        $display("FAIL rnd_data[%0d] a=%h u=%b x=%b got %h want %h",
                 it, addr, unit, ext, d, exp_d);
      end
    end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_directed;
    test_hold;
    test_reset_wait;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
